// File: rtl/atconv_mem_host.sv
// atconv_mem_host: host-side responder for the ATCONV accelerator.
// Owns the image memory and both layer memories. It loads the image from a
// pixel stream, hands off with ready/busy, serves accelerator accesses while
// busy is high, then offers a readback port for dumping the layer results.
// Optional feature macro: ATCONV_HOST_WRCNT_EN adds saturating per-layer
// write counters (l0_wr_cnt, l1_wr_cnt).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for the first pixel of an image
// LOAD    | streaming pixels into image memory, cnt = next write address
// HANDOFF | image complete, ready=1, waiting for busy to rise
// RUN     | accelerator owns the memories until busy falls
// DONE    | results stable, readback enabled, next pixel restarts a load
module atconv_mem_host #(
    parameter int DW        = 13,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = 4096,
    parameter int L0_DEPTH  = 4096,
    parameter int L1_DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          csel,
    output logic          done,
    output logic          l0_written,
    output logic          l1_written,
    input  logic          rb_en,
    input  logic          rb_sel,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    output logic          rb_valid
`ifdef ATCONV_HOST_WRCNT_EN
    ,
    output logic [12:0]   l0_wr_cnt,
    output logic [10:0]   l1_wr_cnt
`endif
);

    localparam int IMW = $clog2(IMG_DEPTH);
    localparam int L0W = $clog2(L0_DEPTH);
    localparam int L1W = $clog2(L1_DEPTH);
    localparam logic [IMW-1:0] CNT_LAST = IMW'(IMG_DEPTH - 1);
    localparam logic [AW:0]    L1_LIM   = (AW+1)'(L1_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HANDOFF, S_RUN, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [IMW-1:0] cnt_q, cnt_d;
    logic           img_we;
    logic [IMW-1:0] img_waddr;

    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0_mem  [L0_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    logic          ready_q, l0_wr_q, l1_wr_q, rb_valid_q;
    logic [DW-1:0] idata_q, cdata_rd_q, rb_data_q;

    logic run_st, done_st, hs_entry;
    logic l0_we, l1_we, l1_wr_ok, l1_rd_ok, rb_l1_ok;

    assign run_st   = (state_q == S_RUN);
    assign done_st  = (state_q == S_DONE);
    assign hs_entry = (state_d == S_HANDOFF) && (state_q != S_HANDOFF);

    // L1 is smaller than the address space; anything beyond it is a hole.
    assign l1_wr_ok = ({1'b0, caddr_wr} < L1_LIM);
    assign l1_rd_ok = ({1'b0, caddr_rd} < L1_LIM);
    assign rb_l1_ok = ({1'b0, rb_addr}  < L1_LIM);

    assign l0_we = run_st && cwr && !csel;
    assign l1_we = run_st && cwr &&  csel && l1_wr_ok;

    // State and load-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, load handshake and image write strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        img_we    = 1'b0;
        img_waddr = cnt_q;
        ld_ready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    img_we    = 1'b1;
                    img_waddr = '0;
                    cnt_d     = IMW'(1);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    img_we = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_HANDOFF;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HANDOFF: begin
                if (busy) state_d = S_RUN;
            end
            S_RUN: begin
                // RUN is only entered with busy high, so low here is the fall.
                if (!busy) state_d = S_DONE;
            end
            S_DONE: begin
                // A new pixel restarts loading; it lands at address 0.
                if (ld_valid) begin
                    img_we    = 1'b1;
                    img_waddr = '0;
                    cnt_d     = IMW'(1);
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Hold off the stream while reset is asserted so no pixel is lost.
        if (reset) begin
            ld_ready = 1'b0;
            img_we   = 1'b0;
        end
    end

    // Memory arrays: contents survive reset.
    always_ff @(posedge clk) begin
        if (img_we) img_mem[img_waddr]            <= ld_data;
        if (l0_we)  l0_mem[caddr_wr[L0W-1:0]]     <= cdata_wr;
        if (l1_we)  l1_mem[caddr_wr[L1W-1:0]]     <= cdata_wr;
    end

    // Handoff flag, image read port and layer read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b0;
            idata_q    <= '0;
            cdata_rd_q <= '0;
        end else begin
            ready_q <= (state_d == S_HANDOFF);
            idata_q <= run_st ? img_mem[iaddr[IMW-1:0]] : '0;
            // Read sees pre-write data on a same-edge collision.
            if (run_st && crd) begin
                if (csel) cdata_rd_q <= l1_rd_ok ? l1_mem[caddr_rd[L1W-1:0]] : '0;
                else      cdata_rd_q <= l0_mem[caddr_rd[L0W-1:0]];
            end
        end
    end

    // Per-run written flags, cleared as a new image is handed off.
    always_ff @(posedge clk) begin
        if (reset || hs_entry) begin
            l0_wr_q <= 1'b0;
            l1_wr_q <= 1'b0;
        end else begin
            if (l0_we) l0_wr_q <= 1'b1;
            if (l1_we) l1_wr_q <= 1'b1;
        end
    end

    // Readback port, live only in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= done_st && rb_en;
            if (done_st && rb_en) begin
                if (rb_sel) rb_data_q <= rb_l1_ok ? l1_mem[rb_addr[L1W-1:0]] : '0;
                else        rb_data_q <= l0_mem[rb_addr[L0W-1:0]];
            end
        end
    end

`ifdef ATCONV_HOST_WRCNT_EN
    logic [12:0] l0_cnt_q;
    logic [10:0] l1_cnt_q;

    // Saturating accepted-write counters, restarted with each handoff.
    always_ff @(posedge clk) begin
        if (reset || hs_entry) begin
            l0_cnt_q <= '0;
            l1_cnt_q <= '0;
        end else begin
            if (l0_we && (l0_cnt_q != '1)) l0_cnt_q <= l0_cnt_q + 1'b1;
            if (l1_we && (l1_cnt_q != '1)) l1_cnt_q <= l1_cnt_q + 1'b1;
        end
    end

    assign l0_wr_cnt = l0_cnt_q;
    assign l1_wr_cnt = l1_cnt_q;
`endif

    assign ready      = ready_q;
    assign idata      = idata_q;
    assign cdata_rd   = cdata_rd_q;
    assign done       = done_st;
    assign l0_written = l0_wr_q;
    assign l1_written = l1_wr_q;
    assign rb_data    = rb_data_q;
    assign rb_valid   = rb_valid_q;

endmodule

// File: tb/tb_atconv_mem_host.sv
// Bench for atconv_mem_host: stimulus pushes timed expectations into a
// scoreboard queue; a monitor pops and compares after every clock edge.
module tb_atconv_mem_host;

    localparam int L1D = 1024;

    localparam int S_LDR  = 0;
    localparam int S_RDY  = 1;
    localparam int S_IDAT = 2;
    localparam int S_CRD  = 3;
    localparam int S_DONE = 4;
    localparam int S_L0W  = 5;
    localparam int S_L1W  = 6;
    localparam int S_RBD  = 7;
    localparam int S_RBV  = 8;

    logic        clk = 1'b0;
    logic        reset, ld_valid, busy, cwr, crd, csel, rb_en, rb_sel;
    logic [12:0] ld_data, cdata_wr;
    logic [11:0] iaddr, caddr_wr, caddr_rd, rb_addr;
    logic        ld_ready, ready, done, l0_written, l1_written, rb_valid;
    logic [12:0] idata, cdata_rd, rb_data;
`ifdef ATCONV_HOST_WRCNT_EN
    logic [12:0] l0_wr_cnt;
    logic [10:0] l1_wr_cnt;
`endif

    atconv_mem_host dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .done(done), .l0_written(l0_written), .l1_written(l1_written),
        .rb_en(rb_en), .rb_sel(rb_sel), .rb_addr(rb_addr),
        .rb_data(rb_data), .rb_valid(rb_valid)
`ifdef ATCONV_HOST_WRCNT_EN
        , .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] rb_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference model: plain arrays of what each memory should hold.
    logic [12:0] img_m [4096];
    logic [12:0] l0_m  [4096];
    logic [12:0] l1_m  [L1D];
    bit          l0_k  [4096];
    bit          l1_k  [L1D];
    bit          l0w, l1w, last_known;
    logic [12:0] last_rd;

    function automatic logic [31:0] probe(input int s);
        case (s)
            S_LDR:   return 32'(ld_ready);
            S_RDY:   return 32'(ready);
            S_IDAT:  return 32'(idata);
            S_CRD:   return 32'(cdata_rd);
            S_DONE:  return 32'(done);
            S_L0W:   return 32'(l0_written);
            S_L1W:   return 32'(l1_written);
            S_RBD:   return 32'(rb_data);
            default: return 32'(rb_valid);
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            S_LDR:   return "ld_ready";
            S_RDY:   return "ready";
            S_IDAT:  return "idata";
            S_CRD:   return "cdata_rd";
            S_DONE:  return "done";
            S_L0W:   return "l0_written";
            S_L1W:   return "l1_written";
            S_RBD:   return "rb_data";
            default: return "rb_valid";
        endcase
    endfunction

    // Monitor: after each edge, compare everything due on this edge.
    initial begin
        exp_t        e;
        logic [12:0] rv;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.due != cyc || probe(e.sig) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d due=%0d got=%0h want=%0h",
                             sname(e.sig), cyc, e.due, probe(e.sig), e.val);
                end
            end
            if (rb_valid) begin
                n_cmp++;
                if (rb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rb_unexpected cyc=%0d got=%0h want=no_readback", cyc, rb_data);
                end else begin
                    rv = rb_q.pop_front();
                    if (rb_data !== rv) begin
                        n_fail++;
                        $display("FAIL rb_data_sb cyc=%0d got=%0h want=%0h", cyc, rb_data, rv);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic nstep();
        @(negedge clk);
        ld_valid = 1'b0;
        cwr      = 1'b0;
        crd      = 1'b0;
        rb_en    = 1'b0;
    endtask

    task automatic expect_at(input int s, input logic [31:0] v);
        exp_t e;
        e.due = cyc + 1;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            nstep();
            reset    = 1'b1;
            ld_valid = 1'b1;
            for (int s = S_LDR; s <= S_RBV; s++) expect_at(s, 32'd0);
        end
        nstep();
        reset = 1'b0;
        expect_at(S_LDR, 32'd1);
        expect_at(S_RDY, 32'd0);
        last_rd    = '0;
        last_known = 1'b1;
        l0w        = 1'b0;
        l1w        = 1'b0;
    endtask

    task automatic load_image(input int n, input bit ramp);
        logic [12:0] v;
        for (int k = 0; k < n; k++) begin
            nstep();
            v        = ramp ? 13'(k) : 13'($urandom_range(0, 8191));
            ld_valid = 1'b1;
            ld_data  = v;
            img_m[k] = v;
            expect_at(S_DONE, 32'd0);
            if (k == 4095) begin
                expect_at(S_RDY, 32'd1);
                expect_at(S_LDR, 32'd0);
            end else begin
                expect_at(S_RDY, 32'd0);
                expect_at(S_LDR, 32'd1);
            end
            if (k < n - 1 && $urandom_range(0, 3) == 0) begin
                nstep();
                ld_data = 13'($urandom_range(0, 8191));
                expect_at(S_LDR, 32'd1);
                expect_at(S_RDY, 32'd0);
            end
        end
    endtask

    task automatic handoff();
        for (int i = 0; i < 3; i++) begin
            nstep();
            ld_valid = 1'b1;
            ld_data  = 13'($urandom_range(0, 8191));
            expect_at(S_RDY, 32'd1);
            expect_at(S_LDR, 32'd0);
        end
        nstep();
        busy = 1'b1;
        l0w  = 1'b0;
        l1w  = 1'b0;
        expect_at(S_RDY,  32'd0);
        expect_at(S_IDAT, 32'd0);
        expect_at(S_L0W,  32'd0);
        expect_at(S_L1W,  32'd0);
    endtask

    task automatic img_rd(input int a);
        nstep();
        iaddr = 12'(a);
        expect_at(S_IDAT, 32'(img_m[a]));
    endtask

    task automatic layer(input bit w, input bit r, input bit sel,
                         input int wa, input logic [12:0] wd, input int ra);
        int a;
        nstep();
        cwr      = w;
        crd      = r;
        csel     = sel;
        caddr_wr = 12'(wa);
        cdata_wr = wd;
        caddr_rd = 12'(ra);
        a        = $urandom_range(0, 4095);
        iaddr    = 12'(a);
        expect_at(S_IDAT, 32'(img_m[a]));
        if (r) begin
            if (sel && ra >= L1D) begin
                last_rd    = '0;
                last_known = 1'b1;
            end else if (sel) begin
                last_rd    = l1_m[ra];
                last_known = l1_k[ra];
            end else begin
                last_rd    = l0_m[ra];
                last_known = l0_k[ra];
            end
        end
        if (w) begin
            if (!sel) begin
                l0_m[wa] = wd;
                l0_k[wa] = 1'b1;
                l0w      = 1'b1;
            end else if (wa < L1D) begin
                l1_m[wa] = wd;
                l1_k[wa] = 1'b1;
                l1w      = 1'b1;
            end
        end
        if (last_known) expect_at(S_CRD, 32'(last_rd));
        expect_at(S_L0W, 32'(l0w));
        expect_at(S_L1W, 32'(l1w));
    endtask

    task automatic rb(input bit sel, input int a);
        nstep();
        rb_en   = 1'b1;
        rb_sel  = sel;
        rb_addr = 12'(a);
        expect_at(S_RBV, 32'd1);
        expect_at(S_DONE, 32'd1);
        if (sel) rb_q.push_back((a < L1D) ? l1_m[a] : 13'd0);
        else     rb_q.push_back(l0_m[a]);
    endtask

    function automatic int pick(input bit sel);
        if (sel) return 1008 + int'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 15));
        return 4080 + int'($urandom_range(0, 15));
    endfunction

    initial begin
        bit s;
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; busy = 1'b0;
        iaddr = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        crd = 1'b0; caddr_rd = '0; csel = 1'b0;
        rb_en = 1'b0; rb_sel = 1'b0; rb_addr = '0;
        for (int i = 0; i < 4096; i++) l0_k[i] = 1'b0;
        for (int i = 0; i < L1D; i++)  l1_k[i] = 1'b0;

        do_reset(3);
        load_image(4096, 1'b1);
        handoff();

        img_rd(37);
        for (int i = 0; i < 30; i++) img_rd(int'($urandom_range(0, 4095)));
        img_rd(0);
        img_rd(4095);

        layer(1, 0, 0, 100, 13'h0ABC, 0);
        layer(0, 1, 0, 0, 13'h0, 100);
        layer(1, 0, 1, 1024, 13'h1555, 0);
        layer(0, 1, 1, 0, 13'h0, 1024);
        layer(1, 0, 1, 5, 13'h0011, 0);
        layer(1, 1, 1, 5, 13'h0022, 5);
        layer(0, 1, 1, 0, 13'h0, 5);

        for (int a = 0; a < 16; a++) begin
            layer(1, 0, 0, a,        13'($urandom_range(0, 8191)), 0);
            layer(1, 0, 0, 4080 + a, 13'($urandom_range(0, 8191)), 0);
            layer(1, 0, 1, 1008 + a, 13'($urandom_range(0, 8191)), 0);
        end
        for (int i = 0; i < 80; i++) begin
            s = 1'($urandom_range(0, 1));
            layer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s,
                  pick(s), 13'($urandom_range(0, 8191)), pick(s));
        end

        nstep();
        busy = 1'b0;
        expect_at(S_DONE, 32'd1);
        nstep();
        cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd100; cdata_wr = 13'h1FFF;
        crd = 1'b1; caddr_rd = 12'd4095;
        expect_at(S_IDAT, 32'd0);
        expect_at(S_DONE, 32'd1);
        expect_at(S_CRD, 32'(last_rd));
        expect_at(S_L0W, 32'(l0w));
        expect_at(S_RBV, 32'd0);

        rb(1, 5);
        nstep();
        expect_at(S_RBV, 32'd0);
        rb(0, 100);
        rb(1, 2000);
        rb(1, 1024);
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                nstep();
                expect_at(S_RBV, 32'd0);
            end else begin
                rb(s, pick(s));
            end
        end

        load_image(2000, 1'b0);
        do_reset(2);
        load_image(4096, 1'b0);
        handoff();
        img_rd(0);
        for (int i = 0; i < 20; i++) img_rd(int'($urandom_range(0, 4095)));
        layer(0, 1, 0, 0, 13'h0, 100);
        layer(0, 1, 1, 0, 13'h0, 5);
        nstep();
        busy = 1'b0;
        expect_at(S_DONE, 32'd1);
        nstep();
        expect_at(S_DONE, 32'd1);
        expect_at(S_RBV, 32'd0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0 || rb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover got=%0d/%0d want=0/0", sb.size(), rb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
